// File: rtl/pipe_bus_ctrl.sv
// Pipeline control and single-port bus arbiter for the five-stage core.
// Arbitrates fetch vs. data accesses, merges stall sources, sequences flush.
module pipe_bus_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_from_id,
  input  logic              stallreq_from_ex,
  input  logic              flush_req,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [3:0]        mem_sel,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [3:0]        bus_sel,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic [5:0]        stall,
  output logic              flush
);

  typedef enum logic [2:0] {
    IDLE,
    MEM_ACC,
    IF_ACC,
    MEM_DONE,
    IF_DONE
  } state_e;

  state_e state_q, state_d;
  logic   flush_pend_q, flush_pend_d;

  logic              bus_req_q, bus_we_q;
  logic [3:0]        bus_sel_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic [DATA_W-1:0] if_rdata_q, mem_rdata_q;

  logic in_acc, acc_ack, acc_flush, start_mem, start_if, cap_mem, cap_if;
  logic wait_mem, wait_if;

  // Decode of the current cycle's bus events
  always_comb begin
    in_acc    = (state_q == MEM_ACC) || (state_q == IF_ACC);
    acc_ack   = in_acc && bus_ack;
    // A flush raised in the same cycle as the ack is folded into that ack
    acc_flush = acc_ack && (flush_pend_q || flush_req);
    start_mem = (state_q == IDLE) && !flush_req && mem_req;
    start_if  = (state_q == IDLE) && !flush_req && !mem_req && if_req;
    cap_mem   = (state_q == MEM_ACC) && bus_ack && !acc_flush;
    cap_if    = (state_q == IF_ACC) && bus_ack && !acc_flush;
    wait_mem  = mem_req && (state_q != MEM_DONE);
    wait_if   = if_req && (state_q != IF_DONE);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    case (state_q)
      IDLE: begin
        if (flush_req)    state_d = IDLE;
        else if (mem_req) state_d = MEM_ACC;
        else if (if_req)  state_d = IF_ACC;
      end
      MEM_ACC, IF_ACC: begin
        if (acc_flush) begin
          state_d      = IDLE;
          flush_pend_d = 1'b0;
        end else if (bus_ack) begin
          state_d = (state_q == MEM_ACC) ? MEM_DONE : IF_DONE;
        end else if (flush_req) begin
          flush_pend_d = 1'b1;
        end
      end
      MEM_DONE, IF_DONE: state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  // Output logic: flush pulse and prioritised stall vector
  always_comb begin
    flush = 1'b0;
    stall = 6'b000000;
    if (!rst) begin
      flush = in_acc ? acc_flush : flush_req;
      if (flush_pend_q)                      stall = 6'b111111;
      else if (flush)                        stall = 6'b000000;
      else if (wait_mem)                     stall = 6'b011111;
      else if (stallreq_from_ex)             stall = 6'b001111;
      else if (stallreq_from_id || wait_if)  stall = 6'b000111;
    end
  end

  // Bus request registers and read-data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      if (start_mem) begin
        bus_req_q   <= 1'b1;
        bus_we_q    <= mem_we;
        bus_sel_q   <= mem_sel;
        bus_addr_q  <= mem_addr;
        bus_wdata_q <= mem_wdata;
      end else if (start_if) begin
        bus_req_q   <= 1'b1;
        bus_we_q    <= 1'b0;
        bus_sel_q   <= 4'hF;
        bus_addr_q  <= if_addr;
        bus_wdata_q <= '0;
      end else if (acc_ack) begin
        bus_req_q   <= 1'b0;
      end
      if (cap_mem) mem_rdata_q <= bus_rdata;
      if (cap_if)  if_rdata_q  <= bus_rdata;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_sel   = bus_sel_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;

endmodule
